// File: rtl/swipt_data_tx.sv
// rtl/swipt_data_tx.sv - SWIPT downlink framer: amplitude-keys a byte onto the SwiptOut duty value
module swipt_data_tx #(
  parameter logic [19:0] BIT_CYCLES = 20'd1000,
  parameter logic [3:0]  GUARD_BITS = 4'd2
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        swiptAlive,
  input  logic        enable,
  input  logic [11:0] l_nominal,
  input  logic [11:0] l_depth,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [11:0] l_out,
  output logic        busy,
  output logic        tx_done,
  output logic        tx_abort
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_GUARD
  } state_t;

  state_t      state_q;
  logic [19:0] cnt_q;
  logic [19:0] cnt_d;
  logic [2:0]  bit_idx_q;
  logic [2:0]  bit_idx_d;
  logic [3:0]  guard_q;
  logic [7:0]  data_q;
  logic [11:0] nom_q;
  logic [11:0] depth_q;
  logic [11:0] l_out_q;
  logic        done_q;
  logic        abort_q;
  logic        sym_end;
  logic        link_ok;

  // '0' symbols dip by the depth, floored at zero rather than wrapping
  function automatic logic [11:0] level(input logic b, input logic [11:0] nom,
                                        input logic [11:0] dep);
    if (b)
      return nom;
    else if (dep > nom)
      return 12'd0;
    else
      return nom - dep;
  endfunction

  assign link_ok   = swiptAlive && enable;
  assign sym_end   = (cnt_q == BIT_CYCLES - 20'd1);
  assign cnt_d     = sym_end ? 20'd0 : cnt_q + 20'd1;
  assign bit_idx_d = bit_idx_q + 3'd1;

  assign tx_ready = (state_q == ST_IDLE) && link_ok;
  assign busy     = (state_q != ST_IDLE);
  assign l_out    = l_out_q;
  assign tx_done  = done_q;
  assign tx_abort = abort_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 20'd0;
      bit_idx_q <= 3'd0;
      guard_q   <= 4'd0;
      data_q    <= 8'd0;
      nom_q     <= 12'd0;
      depth_q   <= 12'd0;
      l_out_q   <= 12'hC8;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      if (state_q != ST_IDLE && !link_ok) begin
        // abort wins even on the final stop-bit cycle, so tx_done is suppressed
        state_q   <= ST_IDLE;
        l_out_q   <= l_nominal;
        abort_q   <= 1'b1;
        cnt_q     <= 20'd0;
        bit_idx_q <= 3'd0;
        guard_q   <= 4'd0;
      end else if (state_q == ST_IDLE) begin
        l_out_q <= l_nominal;
        if (tx_valid && tx_ready) begin
          data_q    <= tx_data;
          nom_q     <= l_nominal;
          depth_q   <= l_depth;
          l_out_q   <= level(1'b0, l_nominal, l_depth);
          state_q   <= ST_START;
          cnt_q     <= 20'd0;
          bit_idx_q <= 3'd0;
        end
      end else begin
        cnt_q <= cnt_d;
        if (sym_end) begin
          case (state_q)
            ST_START: begin
              state_q   <= ST_DATA;
              bit_idx_q <= 3'd0;
              l_out_q   <= level(data_q[0], nom_q, depth_q);
            end
            ST_DATA: begin
              if (bit_idx_q == 3'd7) begin
                state_q <= ST_PARITY;
                l_out_q <= level(^data_q, nom_q, depth_q);
              end else begin
                bit_idx_q <= bit_idx_d;
                l_out_q   <= level(data_q[bit_idx_d], nom_q, depth_q);
              end
            end
            ST_PARITY: begin
              state_q <= ST_STOP;
              l_out_q <= nom_q;
            end
            ST_STOP: begin
              done_q <= 1'b1;
              if (GUARD_BITS == 4'd0) begin
                state_q <= ST_IDLE;
                l_out_q <= l_nominal;
              end else begin
                state_q <= ST_GUARD;
                guard_q <= 4'd0;
                l_out_q <= nom_q;
              end
            end
            ST_GUARD: begin
              if (guard_q == GUARD_BITS - 4'd1) begin
                state_q <= ST_IDLE;
                guard_q <= 4'd0;
                l_out_q <= l_nominal;
              end else begin
                guard_q <= guard_q + 4'd1;
              end
            end
            default: begin
              state_q <= ST_IDLE;
              l_out_q <= l_nominal;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_swipt_data_tx.sv
// tb/tb_swipt_data_tx.sv - self-checking bench for swipt_data_tx
module tb_swipt_data_tx;

  localparam int BC = 4;
  localparam int G  = 2;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        swiptAlive = 1'b1;
  logic        enable = 1'b1;
  logic [11:0] l_nominal = 12'd200;
  logic [11:0] l_depth = 12'd50;
  logic [7:0]  tx_data = 8'd0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [11:0] l_out;
  logic        busy;
  logic        tx_done;
  logic        tx_abort;

  int errors = 0;
  int checks = 0;

  swipt_data_tx #(.BIT_CYCLES(20'd4), .GUARD_BITS(4'd2)) dut (
    .clk(clk), .nrst(nrst), .swiptAlive(swiptAlive), .enable(enable),
    .l_nominal(l_nominal), .l_depth(l_depth), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .l_out(l_out), .busy(busy),
    .tx_done(tx_done), .tx_abort(tx_abort)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int lvl(input bit b, input int nom, input int dep);
    if (b) return nom;
    return (dep > nom) ? 0 : nom - dep;
  endfunction

  // Frame model: waveform indexed by cycles since acceptance
  int  m_sym [11];
  int  m_nom_lat = 0;
  int  m_pos = 0;
  bit  m_busy = 0;
  int  m_lout = 12'hC8;
  bit  m_done = 0;
  bit  m_abort = 0;

  always @(posedge clk) begin
    m_done  = 0;
    m_abort = 0;
    if (!nrst) begin
      m_busy = 0;
      m_lout = 12'hC8;
    end else if (!m_busy) begin
      if (tx_valid && enable && swiptAlive) begin
        for (int k = 0; k < 11; k++) begin
          bit b;
          if (k == 0) b = 0;
          else if (k <= 8) b = tx_data[k-1];
          else if (k == 9) b = ^tx_data;
          else b = 1;
          m_sym[k] = lvl(b, l_nominal, l_depth);
        end
        m_nom_lat = l_nominal;
        m_busy = 1;
        m_pos = 0;
        m_lout = m_sym[0];
      end else begin
        m_lout = l_nominal;
      end
    end else if (!(enable && swiptAlive)) begin
      m_busy = 0;
      m_abort = 1;
      m_lout = l_nominal;
    end else begin
      m_pos++;
      if (m_pos == 11*BC) m_done = 1;
      if (m_pos == (11+G)*BC) begin
        m_busy = 0;
        m_lout = l_nominal;
      end else if (m_pos < 11*BC) begin
        m_lout = m_sym[m_pos / BC];
      end else begin
        m_lout = m_nom_lat;
      end
    end
    #1;
    chk("l_out", l_out, m_lout);
    chk("busy", busy, m_busy);
    chk("tx_done", tx_done, m_done);
    chk("tx_abort", tx_abort, m_abort);
    chk("tx_ready", tx_ready, !m_busy && enable && swiptAlive);
  end

  int seen [11];
  int done_at, ready_at, abort_at;

  // Call at a negedge while idle; i counts negedges after the acceptance edge
  task automatic send_watch(input logic [7:0] d, input int abort_i, input bit by_alive);
    tx_data = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    done_at = -1; ready_at = -1; abort_at = -1;
    for (int i = 0; i < 60; i++) begin
      if (i % BC == 1 && i / BC < 11) seen[i / BC] = l_out;
      if (tx_done && done_at < 0) done_at = i;
      if (tx_abort && abort_at < 0) abort_at = i;
      if (tx_ready && ready_at < 0) ready_at = i;
      if (i == abort_i) begin
        if (by_alive) swiptAlive = 1'b0; else enable = 1'b0;
      end
      if (i == abort_i + 1) begin
        swiptAlive = 1'b1;
        enable = 1'b1;
      end
      @(negedge clk);
    end
  endtask

  int exp_a5 [11] = '{150, 200, 150, 200, 150, 150, 200, 150, 200, 150, 200};
  int exp_00 [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 30};
  int acc, dones, acc1_i, acc2_i;
  bit acc_pending;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_l_out", l_out, 12'hC8);
    chk("rst_busy", busy, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_abort", tx_abort, 0);
    nrst = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_l_out", l_out, 200);

    send_watch(8'hA5, -5, 0);
    for (int k = 0; k < 11; k++) chk($sformatf("a5_sym%0d", k), seen[k], exp_a5[k]);
    chk("a5_done_at", done_at, 44);
    chk("a5_ready_at", ready_at, 52);
    chk("a5_abort_at", abort_at, -1);

    l_nominal = 12'd30;
    l_depth = 12'd100;
    repeat (2) @(negedge clk);
    send_watch(8'h00, -5, 0);
    for (int k = 0; k < 11; k++) chk($sformatf("sat_sym%0d", k), seen[k], exp_00[k]);
    chk("sat_done_at", done_at, 44);
    l_nominal = 12'd200;
    l_depth = 12'd50;
    repeat (2) @(negedge clk);

    tx_data = 8'h3C;
    tx_valid = 1'b1;
    acc = 0; dones = 0; acc1_i = -1; acc2_i = -1; acc_pending = 0;
    for (int i = 0; i < 140; i++) begin
      if (tx_done) dones++;
      if (tx_valid && tx_ready) begin
        acc++;
        acc_pending = 1;
        if (acc == 1) acc1_i = i; else acc2_i = i;
      end
      @(negedge clk);
      if (acc_pending) begin
        acc_pending = 0;
        if (acc == 1) tx_data = 8'h81; else tx_valid = 1'b0;
      end
    end
    chk("hold_accepts", acc, 2);
    chk("hold_dones", dones, 2);
    chk("hold_gap", acc2_i - acc1_i, 53);

    send_watch(8'h5A, 37, 1);
    chk("par_abort_at", abort_at, 38);
    chk("par_done_at", done_at, -1);
    chk("par_ready_at", ready_at, 39);

    send_watch(8'h5A, 43, 0);
    chk("last_abort_at", abort_at, 44);
    chk("last_done_at", done_at, -1);

    tx_data = 8'h96;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (14) @(negedge clk);
    chk("mid_busy_pre", busy, 1);
    nrst = 1'b0;
    #1;
    chk("arst_l_out", l_out, 12'hC8);
    chk("arst_busy", busy, 0);
    chk("arst_done", tx_done, 0);
    chk("arst_abort", tx_abort, 0);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    chk("rel_l_out", l_out, 200);
    chk("rel_done", tx_done, 0);
    chk("rel_abort", tx_abort, 0);

    enable = 1'b0;
    tx_valid = 1'b1;
    tx_data = 8'h77;
    #1;
    chk("dis_ready", tx_ready, 0);
    @(negedge clk);
    l_nominal = 12'd123;
    #1;
    chk("dis_l_out_old", l_out, 200);
    @(negedge clk);
    chk("dis_l_out_new", l_out, 123);
    repeat (3) @(negedge clk);
    chk("dis_busy", busy, 0);
    tx_valid = 1'b0;
    enable = 1'b1;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
